// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell processes the
// operands LSB-first, WIDTH cycles per result, with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             bin_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             bout_s;
  logic [WIDTH-1:0] res_next_s;

  // Full-subtractor cell on the current LSBs; its difference bit enters the result from the MSB side
  always_comb begin
    d_s        = a_sh_r[0] ^ b_sh_r[0] ^ bin_r;
    bout_s     = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & bin_r);
    res_next_s = (res_sh_r >> 1) | (WIDTH'(d_s) << (WIDTH - 1));
  end

  // A start is only honoured outside SHIFT; last_s marks the final bit of an operation
  always_comb begin
    accept_s = start && (state_r != SHIFT);
    last_s   = (state_r == SHIFT) && (cnt_r == LAST_CNT);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = SHIFT; else state_s = IDLE;
      SHIFT:   if (last_s) state_s = DONE; else state_s = SHIFT;
      DONE:    if (start) state_s = SHIFT; else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs are registered from the next state so they line up with state_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s == SHIFT);
      done <= (state_s == DONE);
    end
  end

  // Operand/result shift datapath; diff and borrow only move on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      bin_r    <= 1'b0;
      cnt_r    <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
    end else begin
      if (accept_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        res_sh_r <= '0;
        bin_r    <= 1'b0;
        cnt_r    <= '0;
      end else if (state_r == SHIFT) begin
        a_sh_r   <= a_sh_r >> 1;
        b_sh_r   <= b_sh_r >> 1;
        res_sh_r <= res_next_s;
        bin_r    <= bout_s;
        cnt_r    <= cnt_r + CW'(1);
      end else begin
        a_sh_r   <= a_sh_r;
        b_sh_r   <= b_sh_r;
        res_sh_r <= res_sh_r;
        bin_r    <= bin_r;
        cnt_r    <= cnt_r;
      end
      if (last_s) begin
        diff   <= res_next_s;
        borrow <= bout_s;
      end else begin
        diff   <= diff;
        borrow <= borrow;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected {borrow,diff}
// comes from plain 9-bit arithmetic and is checked on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  logic [W:0]   exp_q[$];
  logic [W:0]   last_res;
  int           n_cmp;
  int           n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pop an expectation on every done pulse, otherwise outputs must hold
  always @(negedge clk) begin
    logic [W:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {23'd0, borrow, diff}, {23'd0, e});
        last_res = e;
      end
    end else begin
      check("result_hold", {23'd0, borrow, diff}, {23'd0, last_res});
    end
  end

  // Issue one operation starting at a negedge; returns at the negedge showing done.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int glitch_at);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back({1'b0, x} - {1'b0, y});
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      check("busy_phase", {30'd0, busy, done}, {30'd0, 2'b10});
      if (k == glitch_at) begin
        start = 1'b1;
        a = 8'h09;
        b = 8'h01;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("done_pulse", {30'd0, busy, done}, {30'd0, 2'b01});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle", {30'd0, busy, done}, {30'd0, 2'b00});
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    n_cmp = 0;
    n_err = 0;
    last_res = '0;
    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", {21'd0, busy, done, borrow, diff}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First operation launched on the very first edge after reset release
    do_op(8'h05, 8'h03, -1);
    idle_cycle();
    do_op(8'h03, 8'h05, -1);
    idle_cycle();
    do_op(8'h00, 8'hFF, -1);
    idle_cycle();
    do_op(8'hA5, 8'hA5, -1);
    idle_cycle();
    do_op(8'hFF, 8'h00, -1);
    idle_cycle();
    do_op(8'hFF, 8'hFF, -1);
    idle_cycle();

    // Start raised two cycles into SHIFT must be ignored
    do_op(8'h33, 8'h11, 2);
    idle_cycle();

    // Back-to-back: start asserted in DONE re-enters SHIFT directly
    do_op(8'h20, 8'h03, -1);
    do_op(8'h10, 8'h01, -1);
    idle_cycle();

    // Asynchronous reset during SHIFT cycle 4 aborts the operation
    start = 1'b1;
    a = 8'h77;
    b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    last_res = '0;
    exp_q.delete();
    #1 check("async_reset", {21'd0, busy, done, borrow, diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {30'd0, busy, done}, {30'd0, 2'b00});
    end
    do_op(8'h40, 8'h41, -1);
    idle_cycle();

    // Randomised stream, mostly back-to-back, biased toward corner operands
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       x = 8'h00;
        1:       x = 8'hFF;
        default: x = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       y = 8'h00;
        1:       y = 8'hFF;
        2:       y = x;
        default: y = W'($urandom);
      endcase
      do_op(x, y, -1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a subtraction; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend, unsigned; captured only on an accepted start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; captured only on an accepted start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse: diff/borrow valid.
REQ-009 diff  output  WIDTH  result, a - b modulo 2^WIDTH.
REQ-010 borrow  output  1  final borrow out; 1 when a < b (unsigned).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: start=1 SHALL capture a and b into shift registers, clear the borrow flip-flop, clear the bit counter, and go to SHIFT.
REQ-013 SHIFT: each cycle SHALL process one bit LSB-first via a full-subtractor cell.
- d = a0 ^ b0 ^ bin
- bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
- d is shifted into the result register from the MSB side.
- Both operand registers shift right by one.
- bout is registered as the next bin.
REQ-014 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of ceil(log2(WIDTH+1)) bits, then go to DONE.
REQ-015 DONE SHALL last one cycle with done=1, and SHALL go to SHIFT if start=1 in that cycle (new operands captured), else to IDLE.
REQ-016 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-017 Latency: start accepted at edge N -> done=1 in the cycle after edge N+WIDTH; back-to-back throughput is one result per WIDTH+1 cycles.
REQ-018 diff and borrow SHALL update only on the SHIFT->DONE transition, and SHALL hold until the next completion or reset.
REQ-019 start while busy=1 SHALL be ignored: no recapture, no state change.
REQ-020 Changes on a/b outside an accepted start SHALL NOT affect the result in progress.
REQ-021 WIDTH=1 SHALL work: one SHIFT cycle, diff = a^b, borrow = ~a & b.
REQ-022 Wrap-around: a<b SHALL yield the two's-complement modulo result with borrow=1; a==b SHALL yield diff=0, borrow=0.

Reset
REQ-023 rst_n=0 SHALL immediately force the following, regardless of clk:
- FSM to IDLE
- busy=0, done=0, diff=0, borrow=0
- operand registers, borrow flip-flop and counter to 0
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-025 After rst_n rises, start SHALL be accepted on the first rising clk edge.

Verification (WIDTH=8)
REQ-026 Scenario: a=5, b=3, start pulse -> busy high 8 cycles, then done=1 for one cycle; diff=0x02, borrow=0.
REQ-027 Scenario: a=3, b=5 -> diff=0xFE, borrow=1; a=0x00, b=0xFF -> diff=0x01, borrow=1; a=b=0xA5 -> diff=0x00, borrow=0.
REQ-028 Scenario: start 2 cycles into busy, with a=9, b=1 on the bus -> ignored; original result delivered, then busy=0.
REQ-029 Scenario: start held high through DONE, with a=0x10, b=0x01 -> next SHIFT begins with no IDLE cycle; second done gives diff=0x0F, borrow=0.
REQ-030 Scenario: rst_n low for 1 cycle during SHIFT cycle 4 -> all outputs 0 asynchronously; no done; a new start after release completes correctly.
REQ-031 Scenario: exhaustive 256x256 operand sweep SHALL match {borrow,diff} = {1'b0,a} - {1'b0,b}, checked on every done pulse.
